// File: rtl/athena_video_out_if.sv
// Bundles the core-side pixel inputs and the scaler-side video/status outputs.
// Latency: none (wiring only).
// Backpressure: none; the stream is paced solely by CE_PIXEL.
interface athena_video_out_if;
    logic        CE_PIXEL;
    logic [3:0]  R;
    logic [3:0]  G;
    logic [3:0]  B;
    logic        HBLANK;
    logic        VBLANK;
    logic        HSYNC;
    logic        VSYNC;
    logic [23:0] video_rgb;
    logic        video_de;
    logic        video_hs;
    logic        video_vs;
    logic [8:0]  active_width;
    logic [8:0]  active_height;
    logic [15:0] frame_count;

    // Core/stimulus side: drives pixels, observes the video stream.
    modport master (
        output CE_PIXEL, R, G, B, HBLANK, VBLANK, HSYNC, VSYNC,
        input  video_rgb, video_de, video_hs, video_vs,
        input  active_width, active_height, frame_count
    );

    // Output-stage side.
    modport slave (
        input  CE_PIXEL, R, G, B, HBLANK, VBLANK, HSYNC, VSYNC,
        output video_rgb, video_de, video_hs, video_vs,
        output active_width, active_height, frame_count
    );
endinterface

// File: rtl/athena_video_out.sv
// Converts core RGB/blank/sync into a 24-bit DE + single-pixel HS/VS strobe stream and measures geometry.
// Latency: one pixel; outputs update on the CE edge that samples the inputs.
// Backpressure: none; every register holds while CE_PIXEL is low.
module athena_video_out #(
    parameter bit          SYNC_ACTIVE_HIGH = 1'b1,
    parameter logic [23:0] BLANK_RGB        = 24'h000000
) (
    input  logic               i_clk,
    input  logic               RESETn,
    athena_video_out_if.slave  bus
);

    logic       hs_in, vs_in, de_in;
    logic       hs_q, vs_q, de_q;
    logic       hs_pend;
    logic       hs_rise, vs_rise, de_fall, hs_fire;
    logic [8:0] width_cnt, height_cnt;
    logic [8:0] height_with_line;

    assign hs_in = SYNC_ACTIVE_HIGH ? bus.HSYNC : ~bus.HSYNC;
    assign vs_in = SYNC_ACTIVE_HIGH ? bus.VSYNC : ~bus.VSYNC;
    assign de_in = ~bus.HBLANK & ~bus.VBLANK;

    // Edge detection against the previously captured pixel; a line that ends on the
    // vs-rise pixel is folded into the height before it is latched.
    always_comb begin
        hs_rise          = hs_in & ~hs_q;
        vs_rise          = vs_in & ~vs_q;
        de_fall          = de_q & ~de_in;
        hs_fire          = hs_rise | hs_pend;
        height_with_line = height_cnt;
        if (de_fall && height_cnt != 9'h1FF) begin
            height_with_line = height_cnt + 9'd1;
        end
    end

    // Capture stage, colour expansion and sync strobes; hs is deferred one pixel on collision with vs.
    always_ff @(posedge i_clk or negedge RESETn) begin
        if (!RESETn) begin
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            de_q          <= 1'b0;
            hs_pend       <= 1'b0;
            bus.video_rgb <= BLANK_RGB;
            bus.video_de  <= 1'b0;
            bus.video_hs  <= 1'b0;
            bus.video_vs  <= 1'b0;
        end else if (bus.CE_PIXEL) begin
            hs_q          <= hs_in;
            vs_q          <= vs_in;
            de_q          <= de_in;
            bus.video_de  <= de_in;
            bus.video_rgb <= de_in ? {bus.R, bus.R, bus.G, bus.G, bus.B, bus.B} : BLANK_RGB;
            bus.video_vs  <= vs_rise;
            if (vs_rise && hs_fire) begin
                bus.video_hs <= 1'b0;
                hs_pend      <= 1'b1;
            end else begin
                bus.video_hs <= hs_fire;
                hs_pend      <= 1'b0;
            end
        end
    end

    // Geometry measurement: saturating width/height counters and a wrapping frame counter.
    always_ff @(posedge i_clk or negedge RESETn) begin
        if (!RESETn) begin
            width_cnt         <= 9'd0;
            height_cnt        <= 9'd0;
            bus.active_width  <= 9'd0;
            bus.active_height <= 9'd0;
            bus.frame_count   <= 16'd0;
        end else if (bus.CE_PIXEL) begin
            if (de_in) begin
                if (width_cnt != 9'h1FF) begin
                    width_cnt <= width_cnt + 9'd1;
                end
            end else if (de_fall) begin
                bus.active_width <= width_cnt;
                width_cnt        <= 9'd0;
            end
            if (vs_rise) begin
                bus.active_height <= height_with_line;
                height_cnt        <= 9'd0;
                bus.frame_count   <= bus.frame_count + 16'd1;
            end else begin
                height_cnt <= height_with_line;
            end
        end
    end

endmodule

// File: tb/tb_athena_video_out.sv
// Directed bench for athena_video_out: colour, strobes, collision, measurement, CE gating, reset.
// Latency: checks sample on the falling edge after each CE edge.
// Backpressure: not applicable; the bench paces pixels with CE_PIXEL.
module tb_athena_video_out;

    logic i_clk  = 1'b0;
    logic RESETn = 1'b1;
    int   tests  = 0;
    int   fails  = 0;
    int   hs_cycles = 0;

    athena_video_out_if vif ();

    athena_video_out dut (
        .i_clk  (i_clk),
        .RESETn (RESETn),
        .bus    (vif.slave)
    );

    always #5 i_clk = ~i_clk;

    // Counts i_clk periods during which video_hs is high.
    always @(negedge i_clk) begin
        if (vif.video_hs === 1'b1) hs_cycles <= hs_cycles + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pixel at the 1-in-8 cadence; returns on the falling edge after the CE edge.
    task automatic pix();
        repeat (7) @(negedge i_clk);
        vif.CE_PIXEL = 1'b1;
        @(negedge i_clk);
        vif.CE_PIXEL = 1'b0;
    endtask

    // One line with CE held high: w DE pixels, then two blank pixels with an hsync pulse.
    task automatic line(input int w);
        vif.VBLANK = 1'b0;
        vif.HBLANK = 1'b0;
        vif.HSYNC  = 1'b0;
        for (int p = 0; p < w; p++) @(negedge i_clk);
        vif.HBLANK = 1'b1;
        vif.HSYNC  = 1'b1;
        @(negedge i_clk);
        vif.HSYNC  = 1'b0;
        @(negedge i_clk);
    endtask

    // h lines of w DE pixels followed by a vsync pulse that latches the height.
    task automatic frame(input int w, input int h);
        vif.CE_PIXEL = 1'b1;
        for (int l = 0; l < h; l++) line(w);
        vif.VBLANK = 1'b1;
        vif.HBLANK = 1'b1;
        vif.VSYNC  = 1'b1;
        @(negedge i_clk);
        vif.VSYNC  = 1'b0;
        @(negedge i_clk);
        vif.CE_PIXEL = 1'b0;
    endtask

    initial begin
        logic [23:0] s_rgb;
        logic        s_de, s_hs, s_vs;
        logic [8:0]  s_aw, s_ah;
        logic [15:0] s_fc;
        int          hs_before;

        vif.CE_PIXEL = 1'b0;
        vif.R = 4'h0; vif.G = 4'h0; vif.B = 4'h0;
        vif.HBLANK = 1'b1; vif.VBLANK = 1'b1;
        vif.HSYNC = 1'b1; vif.VSYNC = 1'b0;

        // Reset state
        #2 RESETn = 1'b0;
        #3;
        chk("rst_rgb", vif.video_rgb, 24'h000000);
        chk("rst_de",  vif.video_de, 1'b0);
        chk("rst_hs",  vif.video_hs, 1'b0);
        chk("rst_vs",  vif.video_vs, 1'b0);
        chk("rst_aw",  vif.active_width, 9'd0);
        chk("rst_ah",  vif.active_height, 9'd0);
        chk("rst_fc",  vif.frame_count, 16'd0);
        repeat (3) @(negedge i_clk);
        RESETn = 1'b1;

        // HSYNC already high at release strobes on the first CE
        pix();
        chk("hs_after_reset", vif.video_hs, 1'b1);
        vif.HSYNC = 1'b0;
        pix();
        chk("hs_after_reset_end", vif.video_hs, 1'b0);

        // Colour expansion and blanking
        vif.R = 4'hA; vif.G = 4'h5; vif.B = 4'hF;
        vif.HBLANK = 1'b0; vif.VBLANK = 1'b0;
        pix();
        chk("rgb_aa55ff", vif.video_rgb, 24'hAA55FF);
        chk("de_active",  vif.video_de, 1'b1);
        vif.HBLANK = 1'b1;
        pix();
        chk("rgb_hblank", vif.video_rgb, 24'h000000);
        chk("de_hblank",  vif.video_de, 1'b0);
        vif.R = 4'h1; vif.G = 4'h2; vif.B = 4'h3; vif.HBLANK = 1'b0;
        pix();
        chk("rgb_112233", vif.video_rgb, 24'h112233);
        vif.VBLANK = 1'b1;
        pix();
        chk("rgb_vblank", vif.video_rgb, 24'h000000);
        chk("de_vblank",  vif.video_de, 1'b0);

        // Strobe width: HSYNC high for 32 pixels gives one 8-cycle pulse
        hs_before = hs_cycles;
        vif.HSYNC = 1'b1;
        pix();
        chk("hs_first_ce", vif.video_hs, 1'b1);
        pix();
        chk("hs_second_ce", vif.video_hs, 1'b0);
        repeat (30) pix();
        chk("hs_pulse_cycles", hs_cycles - hs_before, 8);
        vif.HSYNC = 1'b0;
        pix();
        vif.HSYNC = 1'b1;
        pix();
        chk("hs_rerise", vif.video_hs, 1'b1);
        vif.HSYNC = 1'b0;
        pix();

        // Collision: vs on the shared pixel, hs deferred one pixel
        vif.HSYNC = 1'b1; vif.VSYNC = 1'b1;
        pix();
        chk("coll_vs0", vif.video_vs, 1'b1);
        chk("coll_hs0", vif.video_hs, 1'b0);
        pix();
        chk("coll_vs1", vif.video_vs, 1'b0);
        chk("coll_hs1", vif.video_hs, 1'b1);
        pix();
        chk("coll_hs2", vif.video_hs, 1'b0);
        vif.HSYNC = 1'b0; vif.VSYNC = 1'b0;
        pix();

        // CE gating: five DE pixels, then 100 ungated cycles of random inputs
        vif.R = 4'h9; vif.G = 4'h6; vif.B = 4'h3;
        vif.HBLANK = 1'b0; vif.VBLANK = 1'b0;
        repeat (5) pix();
        s_rgb = vif.video_rgb; s_de = vif.video_de; s_hs = vif.video_hs; s_vs = vif.video_vs;
        s_aw = vif.active_width; s_ah = vif.active_height; s_fc = vif.frame_count;
        for (int c = 0; c < 100; c++) begin
            @(negedge i_clk);
            vif.R = 4'($urandom); vif.G = 4'($urandom); vif.B = 4'($urandom);
            vif.HBLANK = 1'($urandom); vif.VBLANK = 1'($urandom);
            vif.HSYNC = 1'($urandom); vif.VSYNC = 1'($urandom);
        end
        chk("gate_rgb", vif.video_rgb, s_rgb);
        chk("gate_de",  vif.video_de, s_de);
        chk("gate_hs",  vif.video_hs, s_hs);
        chk("gate_vs",  vif.video_vs, s_vs);
        chk("gate_aw",  vif.active_width, s_aw);
        chk("gate_ah",  vif.active_height, s_ah);
        chk("gate_fc",  vif.frame_count, s_fc);
        vif.HBLANK = 1'b1; vif.VBLANK = 1'b0; vif.HSYNC = 1'b0; vif.VSYNC = 1'b0;
        pix();
        chk("gate_width_held", vif.active_width, 9'd5);

        // Measurement from a clean reset
        vif.HBLANK = 1'b1; vif.VBLANK = 1'b1;
        @(negedge i_clk);
        #2 RESETn = 1'b0;
        @(negedge i_clk);
        RESETn = 1'b1;
        frame(8, 4);
        chk("f1_width",  vif.active_width, 9'd8);
        chk("f1_height", vif.active_height, 9'd4);
        chk("f1_count",  vif.frame_count, 16'd1);
        frame(8, 4);
        chk("f2_count",  vif.frame_count, 16'd2);
        frame(256, 224);
        chk("f3_width",  vif.active_width, 9'd256);
        chk("f3_height", vif.active_height, 9'd224);
        chk("f3_count",  vif.frame_count, 16'd3);

        // 600-pixel DE run saturates the width
        vif.CE_PIXEL = 1'b1;
        line(600);
        vif.CE_PIXEL = 1'b0;
        chk("width_sat", vif.active_width, 9'd511);

        // Asynchronous reset mid-line discards partial counts
        vif.CE_PIXEL = 1'b1;
        repeat (3) line(12);
        vif.HBLANK = 1'b0; vif.VBLANK = 1'b0; vif.R = 4'hC;
        repeat (5) @(negedge i_clk);
        #2 RESETn = 1'b0;
        #1;
        chk("mid_rst_rgb", vif.video_rgb, 24'h000000);
        chk("mid_rst_de",  vif.video_de, 1'b0);
        chk("mid_rst_aw",  vif.active_width, 9'd0);
        chk("mid_rst_ah",  vif.active_height, 9'd0);
        chk("mid_rst_fc",  vif.frame_count, 16'd0);
        @(negedge i_clk);
        vif.CE_PIXEL = 1'b0;
        vif.HBLANK = 1'b1; vif.VBLANK = 1'b1;
        @(negedge i_clk);
        RESETn = 1'b1;
        frame(12, 6);
        chk("post_rst_width",  vif.active_width, 9'd12);
        chk("post_rst_height", vif.active_height, 9'd6);
        chk("post_rst_count",  vif.frame_count, 16'd1);

        // DE fall and vs rise on the same pixel: the line counts toward the height
        vif.CE_PIXEL = 1'b1;
        repeat (2) line(12);
        vif.HBLANK = 1'b0; vif.VBLANK = 1'b0;
        repeat (12) @(negedge i_clk);
        vif.HBLANK = 1'b1; vif.VBLANK = 1'b1; vif.VSYNC = 1'b1;
        @(negedge i_clk);
        vif.CE_PIXEL = 1'b0;
        chk("coinc_height", vif.active_height, 9'd3);
        chk("coinc_vs",     vif.video_vs, 1'b1);
        chk("coinc_count",  vif.frame_count, 16'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
